// File: rtl/sysctrl_reset_video.sv
// rtl/sysctrl_reset_video.sv - core reset sequencing, video mode hotkey/set and scan decode
// Optional feature macro: SYSCTRL_MODE_LOCK_EN (freeze video_mode while core reset is asserted)
module sysctrl_reset_video #(
  parameter int POR_CYCLES  = 16,
  parameter int RST_STRETCH = 1024,
  parameter int DEBOUNCE    = 4,
  parameter int NMODES      = 3,
  parameter int MODE_W      = 2,
  parameter int INIT_MODE   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              kbd_reset_n,
  input  logic              kbd_mreset_n,
  input  logic              change_video_output,
  input  logic              mode_set_valid,
  input  logic [MODE_W-1:0] mode_set_value,
  output logic              core_reset_n,
  output logic              cold_boot,
  output logic [MODE_W-1:0] video_mode,
  output logic              enable_scandoubling,
  output logic              disable_scaneffect,
  output logic              mode_changed
);

  localparam int CMAX  = (POR_CYCLES > RST_STRETCH) ? POR_CYCLES : RST_STRETCH;
  localparam int CNT_W = $clog2(CMAX) + 1;
  localparam int DB_W  = $clog2(DEBOUNCE + 1);

  typedef enum logic [1:0] {ST_POR, ST_RUN, ST_WARM} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [DB_W-1:0]    db_cnt;
  logic               db_level, db_level_d;
  logic               advance, mode_ok, cold_load, set_ok;
  logic [MODE_W-1:0]  mode_nxt;

  // Master reset wins from every state, including an in-progress POR.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (!kbd_mreset_n) begin
      state_nxt = ST_POR;
      cnt_nxt   = '0;
    end else begin
      case (state)
        ST_POR: begin
          if (cnt == CNT_W'(POR_CYCLES - 1)) begin
            state_nxt = ST_RUN;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        ST_RUN: begin
          if (!kbd_reset_n) begin
            state_nxt = ST_WARM;
            cnt_nxt   = '0;
          end
        end
        ST_WARM: begin
          if (cnt < CNT_W'(RST_STRETCH - 1)) cnt_nxt = cnt + CNT_W'(1);
          if (kbd_reset_n && (cnt >= CNT_W'(RST_STRETCH - 1))) begin
            state_nxt = ST_RUN;
            cnt_nxt   = '0;
          end
        end
        default: begin
          state_nxt = ST_POR;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_POR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign core_reset_n = (state == ST_RUN);
  assign cold_boot    = (state == ST_POR);

  // Level sets on the edge the run of high samples reaches DEBOUNCE.
  always_ff @(posedge clk) begin
    if (reset) begin
      db_cnt     <= '0;
      db_level   <= 1'b0;
      db_level_d <= 1'b0;
    end else begin
      db_level_d <= db_level;
      if (!change_video_output) begin
        db_cnt   <= '0;
        db_level <= 1'b0;
      end else begin
        if (db_cnt != DB_W'(DEBOUNCE)) db_cnt <= db_cnt + DB_W'(1);
        if (db_cnt >= DB_W'(DEBOUNCE - 1)) db_level <= 1'b1;
      end
    end
  end

  assign advance = db_level & ~db_level_d;

`ifdef SYSCTRL_MODE_LOCK_EN
  assign mode_ok = (state == ST_RUN);
`else
  assign mode_ok = (state != ST_POR);
`endif

  assign cold_load = ~kbd_mreset_n;
  assign set_ok    = mode_set_valid && ({1'b0, mode_set_value} < (MODE_W + 1)'(NMODES));

  always_comb begin
    mode_nxt = video_mode;
    if (cold_load) begin
      mode_nxt = MODE_W'(INIT_MODE);
    end else if (mode_ok) begin
      if (set_ok)
        mode_nxt = mode_set_value;
      else if (advance)
        mode_nxt = (video_mode == MODE_W'(NMODES - 1)) ? '0 : video_mode + MODE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      video_mode   <= MODE_W'(INIT_MODE);
      mode_changed <= 1'b0;
    end else begin
      video_mode   <= mode_nxt;
      mode_changed <= !cold_load && (mode_nxt != video_mode);
    end
  end

  always_comb begin
    enable_scandoubling = 1'b0;
    disable_scaneffect  = 1'b0;
    if (video_mode == MODE_W'(0)) begin
      enable_scandoubling = 1'b1;
      disable_scaneffect  = 1'b1;
    end else if (video_mode == MODE_W'(1)) begin
      enable_scandoubling = 1'b1;
    end
  end

endmodule
